// File: rtl/free_list_mp.sv
// Multi-port physical-register free list for the rename stage.
// Circular FIFO with enqueue forwarding and head checkpoints for rollback.
module free_list_mp #(
    parameter int DEPTH     = 32,
    parameter int WIDTH     = 2,
    parameter int PR_W      = 6,
    parameter int NUM_CKPT  = 4,
    parameter int INIT_FULL = 0,
    parameter int INIT_BASE = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [$clog2(WIDTH+1)-1:0]    deq_cnt,
    output logic [WIDTH*PR_W-1:0]         deq_pr,
    output logic [WIDTH-1:0]              deq_valid,
    input  logic [$clog2(WIDTH+1)-1:0]    enq_cnt,
    input  logic [WIDTH*PR_W-1:0]         enq_pr,
    output logic                          enq_accepted,
    input  logic                          ckpt_save_en,
    input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_save_id,
    input  logic                          ckpt_restore_en,
    input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_restore_id,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          is_empty,
    output logic                          is_full,
    output logic                          restore_error
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    logic [PR_W-1:0] mem [DEPTH];
    ptr_t            ckpt_q [NUM_CKPT];
    ptr_t            head_q;
    ptr_t            tail_q;
    ptr_t            head_d;
    ptr_t            tail_d;
    logic            err_q;

    ptr_t            cnt;
    ptr_t            eff_deq;
    ptr_t            stored_deq;
    ptr_t            space;
    ptr_t            enq_n;
    ptr_t            avail;
    ptr_t            grant;
    ptr_t            ckpt_sel;
    ptr_t            rst_dist;
    logic            restore_ok;

    logic [PR_W-1:0] enq_slot [WIDTH];
    logic [AW-1:0]   rd_idx [WIDTH];
    logic [AW-1:0]   wr_idx [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            ptr_t rp;
            ptr_t wp;
            enq_slot[i] = enq_pr[i*PR_W +: PR_W];
            rp          = head_q + ptr_t'(i);
            wp          = tail_q + ptr_t'(i);
            rd_idx[i]   = rp[AW-1:0];
            wr_idx[i]   = wp[AW-1:0];
        end
    end

    // A restore suppresses allocation, so only stored entries leaving
    // through real dequeues may make room for this cycle's frees.
    always_comb begin
        cnt          = tail_q - head_q;
        eff_deq      = ckpt_restore_en ? '0 : ptr_t'(deq_cnt);
        stored_deq   = (eff_deq < cnt) ? eff_deq : cnt;
        space        = ptr_t'(DEPTH) - cnt + stored_deq;
        enq_accepted = (enq_cnt != '0) && (ptr_t'(enq_cnt) <= space);
        enq_n        = enq_accepted ? ptr_t'(enq_cnt) : '0;
        avail        = cnt + enq_n;
        grant        = (eff_deq < avail) ? eff_deq : avail;
    end

    always_comb begin
        deq_pr    = '0;
        deq_valid = '0;
        for (int i = 0; i < WIDTH; i++) begin
            logic [PR_W-1:0] fwd;
            fwd = '0;
            for (int j = 0; j < WIDTH; j++) begin
                if (ptr_t'(j) + cnt == ptr_t'(i)) begin
                    fwd = enq_slot[j];
                end
            end
            if (ptr_t'(i) < grant) begin
                deq_valid[i] = 1'b1;
                if (ptr_t'(i) < cnt) begin
                    deq_pr[i*PR_W +: PR_W] = mem[rd_idx[i]];
                end else begin
                    deq_pr[i*PR_W +: PR_W] = fwd;
                end
            end
        end
    end

    // A checkpoint older than one full lap of tail would resurrect
    // entries that have since been overwritten, so it is rejected.
    always_comb begin
        tail_d     = tail_q + enq_n;
        ckpt_sel   = ckpt_q[ckpt_restore_id];
        rst_dist   = tail_d - ckpt_sel;
        restore_ok = (rst_dist <= ptr_t'(DEPTH));
        head_d     = head_q + grant;
        if (ckpt_restore_en && restore_ok) begin
            head_d = ckpt_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= (INIT_FULL != 0) ? ptr_t'(DEPTH) : '0;
            err_q  <= 1'b0;
            for (int k = 0; k < NUM_CKPT; k++) begin
                ckpt_q[k] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            if (ckpt_restore_en && !restore_ok) begin
                err_q <= 1'b1;
            end
            if (ckpt_save_en && !ckpt_restore_en) begin
                ckpt_q[ckpt_save_id] <= head_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if (INIT_FULL != 0) begin
                for (int k = 0; k < DEPTH; k++) begin
                    mem[k] <= PR_W'(INIT_BASE + k);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ptr_t'(i) < enq_n) begin
                    mem[wr_idx[i]] <= enq_slot[i];
                end
            end
        end
    end

    assign count         = cnt;
    assign is_empty      = (cnt == '0);
    assign is_full       = (cnt == ptr_t'(DEPTH));
    assign restore_error = err_q;

endmodule
